// File: rtl/mdl_oob_pkg.sv
// Shared definitions for the device-side OOB sequencer bench model:
// FSM state encoding, 8b/10b code groups and the ALIGNp primitive.
package mdl_oob_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CINIT      = 4'd1,
        ST_WAIT_CWAKE = 4'd2,
        ST_CWAKE      = 4'd3,
        ST_WAIT_REL   = 4'd4,
        ST_REL_CNT    = 4'd5,
        ST_ALIGN      = 4'd6,
        ST_LINKUP     = 4'd7,
        ST_FAIL       = 4'd8
    } oob_state_e;

    // Running-disparity-negative encodings
    localparam logic [9:0]  K28_5   = 10'b0011111010;
    localparam logic [9:0]  D10_2   = 10'b0101010101;
    localparam logic [9:0]  D27_3   = 10'b1101100011;
    localparam logic [39:0] ALIGN_P = {K28_5, D10_2, D10_2, D27_3};

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdl_oob_burst_timer.sv
// Burst/idle generator: N_BURST repetitions of UIOOB cycles burst then
// i_idle_len cycles idle; o_done pulses in the last idle cycle.
module mdl_oob_burst_timer
    import mdl_oob_pkg::*;
#(
    parameter int unsigned UIOOB   = 160,
    parameter int unsigned N_BURST = 6,
    parameter int unsigned CNT_W   = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_idle_len,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_burst_en,
    output logic             o_done
);

    localparam int unsigned BW = (N_BURST > 1) ? $clog2(N_BURST) : 1;

    logic             active_q, active_d;
    logic             burst_q, burst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    nb_q, nb_d;
    logic             done;

    always_comb begin
        active_d = active_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        nb_d     = nb_q;
        done     = 1'b0;
        if (i_abort) begin
            active_d = 1'b0;
            burst_d  = 1'b0;
            cnt_d    = '0;
            nb_d     = '0;
        end else if (i_start) begin
            active_d = 1'b1;
            burst_d  = 1'b1;
            cnt_d    = '0;
            nb_d     = '0;
        end else if (active_q) begin
            if (burst_q) begin
                if (cnt_q == CNT_W'(UIOOB - 1)) begin
                    burst_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (cnt_q == i_idle_len - 1'b1) begin
                cnt_d = '0;
                if (nb_q == BW'(N_BURST - 1)) begin
                    done     = 1'b1;
                    active_d = 1'b0;
                    nb_d     = '0;
                end else begin
                    burst_d = 1'b1;
                    nb_d    = nb_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_q <= 1'b0;
            burst_q  <= 1'b0;
            cnt_q    <= '0;
            nb_q     <= '0;
        end else begin
            active_q <= active_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            nb_q     <= nb_d;
        end
    end

    assign o_burst_en = burst_q;
    assign o_done     = done;

endmodule

// File: rtl/mdl_oob_seq.sv
// Device-side OOB sequencer: COMINIT/COMWAKE answer, release wait, ALIGNp until
// host ALIGN detected. Define MDL_OOB_SEQ_RETRY_EN to retry COMINIT after ALIGN timeouts.
module mdl_oob_seq
    import mdl_oob_pkg::*;
#(
    parameter int unsigned UIOOB         = 160,
    parameter int unsigned N_BURST       = 6,
    parameter int unsigned CINIT_IDLE    = 480,
    parameter int unsigned CWAKE_IDLE    = 160,
    parameter int unsigned RELEASE_WAIT  = 1024,
    parameter int unsigned ALIGN_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_comfinish,
    input  logic                           i_comreset_det,
    input  logic                           i_comwake_dev,
    input  logic                           i_comwake_det,
    input  logic                           i_align_det,
    output logic                           o_burst_en,
    output logic                           o_align_en,
    output logic [3:0]                     o_state,
    output logic                           o_linkup,
    output logic                           o_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_cnt
);

    localparam int unsigned CW  = $clog2(max2(max2(UIOOB, CINIT_IDLE),
                                              max2(CWAKE_IDLE, RELEASE_WAIT)) + 1);
    localparam int unsigned AW  = $clog2(ALIGN_TIMEOUT + 1);
    localparam int unsigned RTW = $clog2(MAX_RETRY + 1);

    oob_state_e    state_q, state_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [AW-1:0] acnt_q, acnt_d, acnt_inc;
    logic          start_q, enter_pat, restart;
    logic          align_q, linkup_q, fail_q;
    logic          tmr_burst, tmr_done;
    logic [CW-1:0] idle_len;

`ifdef MDL_OOB_SEQ_RETRY_EN
    logic [RTW-1:0] retry_q, retry_d;
    assign o_retry_cnt = retry_q;
`else
    assign o_retry_cnt = '0;
`endif

    assign restart  = i_comfinish && i_comreset_det;
    assign acnt_inc = acnt_q + 1'b1;
    assign idle_len = (state_q == ST_CWAKE) ? CW'(CWAKE_IDLE) : CW'(CINIT_IDLE);

    always_comb begin
        state_d   = state_q;
        rel_d     = rel_q;
        acnt_d    = acnt_q;
        enter_pat = 1'b0;
`ifdef MDL_OOB_SEQ_RETRY_EN
        retry_d   = retry_q;
`endif
        if (restart) begin
            state_d   = ST_CINIT;
            rel_d     = '0;
            acnt_d    = '0;
            enter_pat = 1'b1;
`ifdef MDL_OOB_SEQ_RETRY_EN
            retry_d   = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_CINIT: if (tmr_done) state_d = ST_WAIT_CWAKE;
                ST_WAIT_CWAKE:
                    if (i_comfinish && i_comwake_dev) begin
                        state_d   = ST_CWAKE;
                        enter_pat = 1'b1;
                    end
                ST_CWAKE: if (tmr_done) state_d = ST_WAIT_REL;
                // The release counter counts observed low cycles of i_comwake_det,
                // so the first low cycle seen here already counts as one.
                ST_WAIT_REL:
                    if (!i_comwake_det) begin
                        state_d = ST_REL_CNT;
                        rel_d   = CW'(1);
                    end
                ST_REL_CNT:
                    if (i_comwake_det) begin
                        rel_d = '0;
                    end else if (rel_q == CW'(RELEASE_WAIT)) begin
                        state_d = ST_ALIGN;
                        rel_d   = '0;
                    end else begin
                        rel_d = rel_q + 1'b1;
                    end
                ST_ALIGN:
                    if (i_align_det) begin
                        state_d = ST_LINKUP;
                        acnt_d  = '0;
                    end else if (acnt_inc == AW'(ALIGN_TIMEOUT)) begin
                        acnt_d = '0;
`ifdef MDL_OOB_SEQ_RETRY_EN
                        if (retry_q < RTW'(MAX_RETRY)) begin
                            retry_d   = retry_q + 1'b1;
                            state_d   = ST_CINIT;
                            enter_pat = 1'b1;
                        end else begin
                            state_d = ST_FAIL;
                        end
`else
                        state_d = ST_FAIL;
`endif
                    end else begin
                        acnt_d = acnt_inc;
                    end
                ST_LINKUP: ;
                ST_FAIL: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            rel_q    <= '0;
            acnt_q   <= '0;
            start_q  <= 1'b0;
            align_q  <= 1'b0;
            linkup_q <= 1'b0;
            fail_q   <= 1'b0;
`ifdef MDL_OOB_SEQ_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rel_q    <= rel_d;
            acnt_q   <= acnt_d;
            start_q  <= enter_pat;
            align_q  <= (state_d == ST_ALIGN) || (state_d == ST_LINKUP);
            linkup_q <= (state_d == ST_LINKUP);
            fail_q   <= (state_d == ST_FAIL);
`ifdef MDL_OOB_SEQ_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    mdl_oob_burst_timer #(
        .UIOOB  (UIOOB),
        .N_BURST(N_BURST),
        .CNT_W  (CW)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_idle_len(idle_len),
        .i_start   (start_q),
        .i_abort   (restart),
        .o_burst_en(tmr_burst),
        .o_done    (tmr_done)
    );

    assign o_burst_en = tmr_burst | align_q;
    assign o_align_en = align_q;
    assign o_state    = state_q;
    assign o_linkup   = linkup_q;
    assign o_fail     = fail_q;

endmodule

// File: tb/tb_mdl_oob_seq.sv
// Directed bench for mdl_oob_seq (ALIGN_TIMEOUT=100, MAX_RETRY=2, other parameters default).
module tb_mdl_oob_seq;

    localparam int UI = 160, NB = 6, CI = 480, CWI = 160, AT = 100, MR = 2;
    localparam logic [3:0] S_IDLE = 4'd0, S_CINIT = 4'd1, S_WCW = 4'd2, S_CWAKE = 4'd3,
                           S_WREL = 4'd4, S_REL = 4'd5, S_ALIGN = 4'd6, S_LINK = 4'd7,
                           S_FAIL = 4'd8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       comfinish = 1'b0, comreset_det = 1'b0, comwake_dev = 1'b0;
    logic       comwake_det = 1'b0, align_det = 1'b0;
    logic       burst_en, align_en, linkup, fail;
    logic [3:0] state;
    logic [1:0] retry;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mdl_oob_seq #(
        .ALIGN_TIMEOUT(AT),
        .MAX_RETRY    (MR)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_comfinish   (comfinish),
        .i_comreset_det(comreset_det),
        .i_comwake_dev (comwake_dev),
        .i_comwake_det (comwake_det),
        .i_align_det   (align_det),
        .o_burst_en    (burst_en),
        .o_align_en    (align_en),
        .o_state       (state),
        .o_linkup      (linkup),
        .o_fail        (fail),
        .o_retry_cnt   (retry)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_comreset();
        comfinish = 1'b1; comreset_det = 1'b1;
        tick();
        comfinish = 1'b0; comreset_det = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] st, input int limit, input string name);
        int n = 0;
        while (state !== st && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (state !== st) begin
            errors++;
            $display("FAIL %s: state=%0d after %0d cycles, required %0d", name, state, n, st);
        end
    endtask

    // Current sample must be the first cycle with burst high.
    task automatic check_pattern(input int idle, input string name);
        int mism = 0, first = -1;
        for (int i = 0; i < NB * (UI + idle); i++) begin
            if (burst_en !== ((i % (UI + idle)) < UI)) begin
                mism++;
                if (first < 0) first = i;
            end
            tick();
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s: %0d wrong burst_en cycles (first at %0d), required 0", name, mism, first);
        end
    endtask

    task automatic cwake_to_align();
        wait_state(S_WCW, 5000, "reach_wait_cwake");
        comwake_det = 1'b1; comfinish = 1'b1; comwake_dev = 1'b1;
        tick();
        comfinish = 1'b0; comwake_dev = 1'b0;
        wait_state(S_WREL, 3000, "reach_wait_rel");
        comwake_det = 1'b0;
        wait_state(S_ALIGN, 1100, "reach_align");
    endtask

    task automatic test_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (state !== S_IDLE) begin
            errors++; $display("FAIL reset_state: state=%0d required 0", state);
        end
        checks++;
        if ({burst_en, align_en, linkup, fail, retry} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: burst=%b align=%b linkup=%b fail=%b retry=%0d required all 0",
                     burst_en, align_en, linkup, fail, retry);
        end
    endtask

    task automatic test_cominit();
        pulse_comreset();
        checks++;
        if (state !== S_CINIT || burst_en !== 1'b0) begin
            errors++; $display("FAIL cinit_entry: state=%0d burst=%b required 1/0", state, burst_en);
        end
        tick();
        checks++;
        if (burst_en !== 1'b1) begin
            errors++; $display("FAIL cinit_first_burst: burst=%b required 1", burst_en);
        end
        check_pattern(CI, "cominit_pattern");
        checks++;
        if (state !== S_WCW || burst_en !== 1'b0) begin
            errors++; $display("FAIL cinit_end: state=%0d burst=%b required 2/0", state, burst_en);
        end
    endtask

    task automatic test_comwake();
        comwake_det = 1'b1; comfinish = 1'b1; comwake_dev = 1'b1;
        tick();
        comfinish = 1'b0; comwake_dev = 1'b0;
        checks++;
        if (state !== S_CWAKE || burst_en !== 1'b0) begin
            errors++; $display("FAIL cwake_entry: state=%0d burst=%b required 3/0", state, burst_en);
        end
        tick();
        check_pattern(CWI, "comwake_pattern");
        repeat (5) tick();
        checks++;
        if (state !== S_WREL) begin
            errors++; $display("FAIL cwake_wait_rel: state=%0d required 4", state);
        end
    endtask

    task automatic test_release_linkup();
        comwake_det = 1'b0;
        tick();
        checks++;
        if (state !== S_REL) begin
            errors++; $display("FAIL rel_entry: state=%0d required 5", state);
        end
        repeat (1023) tick();
        checks++;
        if (align_en !== 1'b0) begin
            errors++; $display("FAIL rel_early_align: align=%b at 1024 required 0", align_en);
        end
        tick();
        checks++;
        if (align_en !== 1'b1 || burst_en !== 1'b1 || state !== S_ALIGN) begin
            errors++;
            $display("FAIL rel_align_rise: align=%b burst=%b state=%0d at 1025 required 1/1/6",
                     align_en, burst_en, state);
        end
        align_det = 1'b1;
        tick();
        align_det = 1'b0;
        checks++;
        if (linkup !== 1'b1 || state !== S_LINK || align_en !== 1'b1) begin
            errors++;
            $display("FAIL linkup: linkup=%b state=%0d align=%b required 1/7/1", linkup, state, align_en);
        end
    endtask

    task automatic test_rel_restart();
        pulse_comreset();
        wait_state(S_WCW, 5000, "rr_wait_cwake");
        comwake_det = 1'b1; comfinish = 1'b1; comwake_dev = 1'b1;
        tick();
        comfinish = 1'b0; comwake_dev = 1'b0;
        wait_state(S_WREL, 3000, "rr_wait_rel");
        comwake_det = 1'b0;
        repeat (500) tick();
        comwake_det = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== S_REL || align_en !== 1'b0) begin
            errors++; $display("FAIL rr_hold: state=%0d align=%b required 5/0", state, align_en);
        end
        comwake_det = 1'b0;
        repeat (1024) tick();
        checks++;
        if (align_en !== 1'b0) begin
            errors++; $display("FAIL rr_early_align: align=%b at 1024 required 0", align_en);
        end
        tick();
        checks++;
        if (align_en !== 1'b1) begin
            errors++; $display("FAIL rr_align_rise: align=%b at 1025 required 1", align_en);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] rexp = 2'd0;
        pulse_comreset();
        cwake_to_align();
`ifdef MDL_OOB_SEQ_RETRY_EN
        for (int r = 1; r <= MR; r++) begin
            repeat (AT - 1) tick();
            checks++;
            if (state !== S_ALIGN) begin
                errors++; $display("FAIL retry_before_timeout: state=%0d required 6", state);
            end
            tick();
            checks++;
            if (state !== S_CINIT || retry !== 2'(r) || align_en !== 1'b0) begin
                errors++;
                $display("FAIL retry_%0d: state=%0d retry=%0d align=%b required 1/%0d/0",
                         r, state, retry, align_en, r);
            end
            cwake_to_align();
        end
        rexp = 2'(MR);
`endif
        repeat (AT - 1) tick();
        checks++;
        if (state !== S_ALIGN) begin
            errors++; $display("FAIL before_timeout: state=%0d required 6", state);
        end
        tick();
        checks++;
        if (state !== S_FAIL || fail !== 1'b1 || burst_en !== 1'b0 || align_en !== 1'b0 || retry !== rexp) begin
            errors++;
            $display("FAIL timeout_fail: state=%0d fail=%b burst=%b align=%b retry=%0d required 8/1/0/0/%0d",
                     state, fail, burst_en, align_en, retry, rexp);
        end
    endtask

    task automatic test_comreset_cwake();
        pulse_comreset();
        checks++;
        if (state !== S_CINIT || retry !== 2'd0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL fail_restart: state=%0d retry=%0d fail=%b required 1/0/0", state, retry, fail);
        end
        wait_state(S_WCW, 5000, "cr_wait_cwake");
        comwake_det = 1'b1; comfinish = 1'b1; comwake_dev = 1'b1;
        tick();
        comfinish = 1'b0; comwake_dev = 1'b0;
        tick();
        repeat (700) tick();
        checks++;
        if (burst_en !== 1'b1 || state !== S_CWAKE) begin
            errors++; $display("FAIL cr_in_burst3: burst=%b state=%0d required 1/3", burst_en, state);
        end
        pulse_comreset();
        comwake_det = 1'b0;
        checks++;
        if (state !== S_CINIT || burst_en !== 1'b0 || retry !== 2'd0) begin
            errors++;
            $display("FAIL cr_abort: state=%0d burst=%b retry=%0d required 1/0/0", state, burst_en, retry);
        end
        tick();
        check_pattern(CI, "cr_fresh_cominit");
        checks++;
        if (state !== S_WCW) begin
            errors++; $display("FAIL cr_end: state=%0d required 2", state);
        end
    endtask

    task automatic test_align_vs_timeout();
        pulse_comreset();
        cwake_to_align();
        repeat (AT - 1) tick();
        align_det = 1'b1;
        tick();
        align_det = 1'b0;
        checks++;
        if (state !== S_LINK || linkup !== 1'b1 || retry !== 2'd0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL align_wins: state=%0d linkup=%b retry=%0d fail=%b required 7/1/0/0",
                     state, linkup, retry, fail);
        end
    endtask

    task automatic test_reset_mid();
        pulse_comreset();
        repeat (50) tick();
        checks++;
        if (burst_en !== 1'b1) begin
            errors++; $display("FAIL mid_pre: burst=%b required 1", burst_en);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (burst_en !== 1'b0 || state !== S_IDLE) begin
            errors++; $display("FAIL mid_reset: burst=%b state=%0d required 0/0", burst_en, state);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (state !== S_IDLE || burst_en !== 1'b0) begin
            errors++; $display("FAIL mid_after: state=%0d burst=%b required 0/0", state, burst_en);
        end
    endtask

    initial begin
        test_reset();
        test_cominit();
        test_comwake();
        test_release_linkup();
        test_rel_restart();
        test_timeout();
        test_comreset_cwake();
        test_align_vs_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mdl_oob_seq.md
# mdl_oob_seq

Parametrised device-side OOB sequencer for the SATA bench model. It answers a host COMRESET with COMINIT and a host COMWAKE with COMWAKE, then streams ALIGNp until the host ALIGNp is detected, and reports link-up. Compared with the previous fixed bench model it adds:
- programmable burst and idle lengths and burst count;
- an ALIGN-detect timeout with bounded retries;
- COMRESET restart from any state.

It drives the existing ALIGNp/burst serializer, which is outside this block.

## Interface
- UIOOB, 160: burst length in i_clk cycles; also the COMWAKE idle unit.
- N_BURST, 6: bursts per COMINIT/COMWAKE pattern, ≥1.
- CINIT_IDLE, 480: COMINIT idle cycles after each burst.
- CWAKE_IDLE, 160: COMWAKE idle cycles after each burst.
- RELEASE_WAIT, 1024: cycles between host COMWAKE release and first ALIGNp.
- ALIGN_TIMEOUT, 65536: ALIGN cycles without i_align_det before the attempt fails.
- MAX_RETRY, 3: COMINIT restarts allowed after ALIGN timeouts.
- i_clk, in, 1: sole clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_comfinish, in, 1: host OOB detector finished classifying a pattern.
- i_comreset_det, in, 1: classified pattern is COMRESET; qualified by i_comfinish.
- i_comwake_dev, in, 1: classified pattern is COMWAKE; qualified by i_comfinish.
- i_comwake_det, in, 1: host still transmitting COMWAKE; level signal.
- i_align_det, in, 1: host ALIGNp received.
- o_burst_en, out, 1: serializer burst enable.
- o_align_en, out, 1: serializer sends ALIGNp words (1) or OOB burst pattern (0).
- o_state, out, 4: current FSM state encoding.
- o_linkup, out, 1: LINKUP state reached.
- o_fail, out, 1: retries exhausted.
- o_retry_cnt, out, $clog2(MAX_RETRY+1): ALIGN timeouts so far in this attempt.

## Operation
- States: IDLE, CINIT, WAIT_CWAKE, CWAKE, WAIT_REL, REL_CNT, ALIGN, LINKUP, FAIL.
- IDLE: i_comfinish && i_comreset_det → CINIT.
- CINIT: N_BURST × (UIOOB cycles o_burst_en=1, then CINIT_IDLE cycles o_burst_en=0). After the Nth idle → WAIT_CWAKE.
- WAIT_CWAKE: i_comfinish && i_comwake_dev → CWAKE.
- CWAKE: same pattern as CINIT, using CWAKE_IDLE. After the Nth idle → WAIT_REL.
- WAIT_REL: wait for !i_comwake_det → REL_CNT.
- REL_CNT: count RELEASE_WAIT cycles while i_comwake_det=0. Counter restarts at 0 if i_comwake_det reasserts. At terminal count → ALIGN.
- ALIGN: o_align_en=1 and o_burst_en=1 continuously, counting cycles.
  - i_align_det → LINKUP.
  - Count reaches ALIGN_TIMEOUT → timeout. If retry_cnt < MAX_RETRY: retry_cnt+1, → CINIT. Otherwise → FAIL.
- LINKUP: o_linkup=1; ALIGNp streaming continues.
- FAIL: o_fail=1, all transmit outputs 0; waits for COMRESET.
- COMRESET restart: i_comfinish && i_comreset_det in any state except IDLE → CINIT.
  - All counters restart at 0.
  - retry_cnt clears, except when entered from an ALIGN timeout.
  - Takes priority over every other transition in the same cycle.
- Counters saturate-free. Widths: burst/idle counter $clog2(max(UIOOB,CINIT_IDLE,CWAKE_IDLE,RELEASE_WAIT)+1); ALIGN counter $clog2(ALIGN_TIMEOUT+1). Compare with == at terminal count.

## Timing
- Reset values: state IDLE; o_burst_en, o_align_en, o_linkup, o_fail = 0; o_retry_cnt = 0; all counters 0.
- All outputs registered.
- o_burst_en rises the cycle after CINIT/CWAKE entry, i.e. 2 cycles after the qualifying i_comfinish.
- One pattern lasts N_BURST×(UIOOB+IDLE) cycles. Defaults: COMINIT 3840, COMWAKE 1920.
- First ALIGNp: o_align_en rises exactly RELEASE_WAIT+1 cycles after i_comwake_det falls, provided there is no re-assertion.
- i_align_det and timeout in the same cycle: i_align_det wins.
- Reset asserted mid-pattern: o_burst_en low on the next edge.

## Configuration
- MDL_OOB_SEQ_RETRY_EN defined: retry behaviour exactly as described above.
- Undefined: the first ALIGN timeout goes directly to FAIL. MAX_RETRY is ignored and o_retry_cnt is tied to 0.

## Structure
- Package mdl_oob_pkg holds:
  - the state enum (4-bit);
  - the K28_5, D10_2 and D27_3 10-bit code constants;
  - the 40-bit ALIGN_P constant, shared with the serializer.
- Sub-module mdl_oob_burst_timer: a burst/idle generator.
  - Parameters: UIOOB, N_BURST.
  - Inputs: idle length, start, abort.
  - Outputs: burst_en, done.
  - Instantiated once and shared by CINIT and CWAKE.

## Test plan
- Reset, then COMRESET with i_comfinish → exactly 6 bursts of 160 high and 480 low; WAIT_CWAKE reached 3840 cycles after o_burst_en first rises.
- COMWAKE qualified → 6 bursts of 160/160. Drop i_comwake_det → o_align_en=1 after 1025 cycles. Assert i_align_det → o_linkup=1 next cycle.
- Set i_comwake_det high again 500 cycles into REL_CNT → counter restarts; ALIGN begins 1025 cycles after the second fall.
- No i_align_det with ALIGN_TIMEOUT=100, MAX_RETRY=2 → two COMINIT restarts, o_retry_cnt reaches 2, o_fail=1 after the third timeout. With the macro undefined, o_fail=1 after the first timeout.
- COMRESET during CWAKE burst 3 → o_burst_en restarts a fresh 6-burst COMINIT pattern; o_retry_cnt=0.
- i_align_det and timeout in the same cycle → LINKUP, not retry.
